// File: rtl/light_sequencer.sv
// Sequencer for the 24-bit lights selector: conditions the push-button, generates timed steps,
// arbitrates the white override and drives the selector's sel/rst/button.
module light_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STEP_CYCLES     = 8,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       mode_auto,
    input  logic       btn_in,
    input  logic       white_req,
    output logic       sel,
    output logic       sel_rst,
    output logic       button,
    output logic [2:0] colour_idx,
    output logic [2:0] state_o
);

    localparam logic [2:0] ST_OFF    = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_MANUAL = 3'd2;
    localparam logic [2:0] ST_AUTO   = 3'd3;
    localparam logic [2:0] ST_WHITE  = 3'd4;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(STEP_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             clean_r;
    logic             clean_d_r;
    logic             press_r;
    logic [CNT_W-1:0] deb_cnt_r;
    logic [CNT_W-1:0] timer_r;
    logic [2:0]       state_r;
    logic             sel_r;
    logic             sel_rst_r;
    logic             button_r;
    logic [2:0]       colour_r;

    logic [2:0]       state_nx_s;
    logic [CNT_W-1:0] timer_nx_s;
    logic             step_s;

    // Colour order 1..6 then wraps to 1; off (0) or an illegal code restarts at 1.
    function automatic logic [2:0] next_colour(input logic [2:0] c);
        logic [2:0] n;
        if ((c >= 3'd1) && (c <= 3'd5)) begin
            n = c + 3'd1;
        end else begin
            n = 3'd1;
        end
        return n;
    endfunction

    // Button synchroniser, debounce counter and one-cycle press strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            clean_r   <= 1'b0;
            clean_d_r <= 1'b0;
            press_r   <= 1'b0;
            deb_cnt_r <= {CNT_W{1'b0}};
        end else begin
            sync1_r <= btn_in;
            sync2_r <= sync1_r;
            if (sync2_r != clean_r) begin
                if (deb_cnt_r == DEB_LAST) begin
                    clean_r   <= sync2_r;
                    deb_cnt_r <= {CNT_W{1'b0}};
                end else begin
                    deb_cnt_r <= deb_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                deb_cnt_r <= {CNT_W{1'b0}};
            end
            clean_d_r <= clean_r;
            press_r   <= clean_r & ~clean_d_r;
        end
    end

    // Next state: disable beats white override, which beats the auto/manual choice.
    always_comb begin
        state_nx_s = ST_OFF;
        if (!enable) begin
            state_nx_s = ST_OFF;
        end else begin
            case (state_r)
                ST_OFF: state_nx_s = ST_INIT;
                ST_INIT, ST_MANUAL, ST_AUTO, ST_WHITE: begin
                    if (white_req) begin
                        state_nx_s = ST_WHITE;
                    end else if (mode_auto) begin
                        state_nx_s = ST_AUTO;
                    end else begin
                        state_nx_s = ST_MANUAL;
                    end
                end
                default: state_nx_s = ST_OFF;
            endcase
        end
    end

    // Step generation and timer; events only fire when the state is unchanged across the edge.
    always_comb begin
        step_s     = 1'b0;
        timer_nx_s = timer_r;
        case (state_nx_s)
            ST_INIT: timer_nx_s = STEP_LOAD;
            ST_MANUAL: begin
                if ((state_r == ST_MANUAL) && press_r && !button_r) begin
                    step_s = 1'b1;
                end else begin
                    step_s = 1'b0;
                end
            end
            ST_AUTO: begin
                if (state_r == ST_AUTO) begin
                    if (timer_r == {CNT_W{1'b0}}) begin
                        step_s     = ~button_r;
                        timer_nx_s = STEP_LOAD;
                    end else begin
                        timer_nx_s = timer_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else if (state_r == ST_MANUAL) begin
                    timer_nx_s = STEP_LOAD;
                end else begin
                    // Coming back from WHITE or INIT keeps the remaining count.
                    timer_nx_s = timer_r;
                end
            end
            default: timer_nx_s = timer_r;
        endcase
    end

    // State, timer and registered selector drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_OFF;
            timer_r   <= {CNT_W{1'b0}};
            sel_r     <= 1'b1;
            sel_rst_r <= 1'b1;
            button_r  <= 1'b0;
            colour_r  <= 3'd0;
        end else begin
            state_r <= state_nx_s;
            timer_r <= timer_nx_s;
            case (state_nx_s)
                ST_OFF, ST_INIT: begin
                    sel_r     <= 1'b1;
                    sel_rst_r <= 1'b1;
                    button_r  <= 1'b0;
                    colour_r  <= 3'd0;
                end
                ST_MANUAL, ST_AUTO: begin
                    sel_r     <= 1'b1;
                    sel_rst_r <= 1'b0;
                    button_r  <= step_s;
                    colour_r  <= step_s ? next_colour(colour_r) : colour_r;
                end
                ST_WHITE: begin
                    sel_r     <= 1'b0;
                    sel_rst_r <= 1'b0;
                    button_r  <= 1'b0;
                    colour_r  <= colour_r;
                end
                default: begin
                    sel_r     <= 1'b1;
                    sel_rst_r <= 1'b1;
                    button_r  <= 1'b0;
                    colour_r  <= 3'd0;
                end
            endcase
        end
    end

    assign sel        = sel_r;
    assign sel_rst    = sel_rst_r;
    assign button     = button_r;
    assign colour_idx = colour_r;
    assign state_o    = state_r;

endmodule
